multicycle_control_fsm: RTL and testbench

//  Moore/Mealy sequencer for the multicycle MIPS datapath. Decodes IR[31:26], steps through

---
 rtl/multicycle_control_fsm_if.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS sequencer and its datapath.
// The sequencer takes the master side: it reads Opcode/MemReady and drives every mux and enable.
interface multicycle_control_fsm_if;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       MulStart;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, MulStart,
               Illegal, State
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, MulStart,
               Illegal, State
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ready stalls
// and a counted wait for the SPECIAL2 multiplier.
module multicycle_control_fsm #(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_EXEC_MUL = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_ALU   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic pc_write_q, pc_write_d;
    logic pc_write_cond_q, pc_write_cond_d;
    logic iord_q, iord_d;
    logic mem_read_q, mem_read_d;
    logic mem_write_q, mem_write_d;
    logic fetch_q, fetch_d;
    logic mem_to_reg_q, mem_to_reg_d;
    logic reg_dst_q, reg_dst_d;
    logic reg_write_q, reg_write_d;
    logic alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic [1:0] pc_source_q, pc_source_d;
    logic mul_start_q, mul_start_d;
    logic illegal_q, illegal_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                casez (bus.Opcode)
                    6'b000000, 6'b011111:            state_d = S_EXEC_R;
                    6'b011100: begin
                        state_d = S_EXEC_MUL;
                        cnt_d   = MUL_LOAD;
                    end
                    6'b100011, 6'b100001, 6'b100000,
                    6'b101011, 6'b101001, 6'b101000: state_d = S_MEM_ADDR;
                    6'b001???:                       state_d = S_EXEC_I;
                    6'b000001, 6'b0001??:            state_d = S_BRANCH;
                    6'b000010:                       state_d = S_JUMP;
                    default:                         state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_EXEC_MUL: begin
                if (cnt_q == 4'd0) state_d = S_WB_ALU;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_MEM_ADDR: state_d = bus.Opcode[3] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.MemReady) state_d = S_WB_MEM;
            S_MEM_WR:   if (bus.MemReady) state_d = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_RESET;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with State.
    always_comb begin
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        iord_d          = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        fetch_d         = 1'b0;
        mem_to_reg_d    = 1'b0;
        reg_dst_d       = 1'b0;
        reg_write_d     = 1'b0;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = 2'b00;
        alu_op_d        = 2'b00;
        pc_source_d     = 2'b00;
        mul_start_d     = 1'b0;
        illegal_d       = 1'b0;
        case (state_d)
            S_FETCH: begin
                fetch_d     = 1'b1;
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;
            end
            S_DECODE: alu_src_b_d = 2'b11;
            S_EXEC_R: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
                alu_op_d    = 2'b10;
            end
            S_EXEC_MUL: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
                mul_start_d = (state_q != S_EXEC_MUL);
            end
            S_MEM_ADDR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MEM_RD: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
            end
            // WB_ALU is only reached from an EXEC state; I-type writes rt, the rest write rd.
            S_WB_ALU: begin
                reg_write_d = 1'b1;
                reg_dst_d   = (state_q != S_EXEC_I);
            end
            S_WB_MEM: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_d     = 1'b1;
                alu_op_d        = 2'b01;
                pc_write_cond_d = 1'b1;
                pc_source_d     = 2'b01;
            end
            S_JUMP: begin
                pc_write_d  = 1'b1;
                pc_source_d = 2'b10;
            end
            S_TRAP:  illegal_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q         <= S_RESET;
            cnt_q           <= 4'd0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            iord_q          <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            fetch_q         <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_dst_q       <= 1'b0;
            reg_write_q     <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            alu_op_q        <= 2'b00;
            pc_source_q     <= 2'b00;
            mul_start_q     <= 1'b0;
            illegal_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pc_write_q      <= pc_write_d;
            pc_write_cond_q <= pc_write_cond_d;
            iord_q          <= iord_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            fetch_q         <= fetch_d;
            mem_to_reg_q    <= mem_to_reg_d;
            reg_dst_q       <= reg_dst_d;
            reg_write_q     <= reg_write_d;
            alu_src_a_q     <= alu_src_a_d;
            alu_src_b_q     <= alu_src_b_d;
            alu_op_q        <= alu_op_d;
            pc_source_q     <= pc_source_d;
            mul_start_q     <= mul_start_d;
            illegal_q       <= illegal_d;
        end
    end

    // Instruction fetch completion is the only Mealy path: IR and PC load the cycle memory answers.
    assign bus.PCWrite     = pc_write_q | (fetch_q & bus.MemReady);
    assign bus.IRWrite     = fetch_q & bus.MemReady;
    assign bus.PCWriteCond = pc_write_cond_q;
    assign bus.IorD        = iord_q;
    assign bus.MemRead     = mem_read_q;
    assign bus.MemWrite    = mem_write_q;
    assign bus.MemtoReg    = mem_to_reg_q;
    assign bus.RegDst      = reg_dst_q;
    assign bus.RegWrite    = reg_write_q;
    assign bus.ALUSrcA     = alu_src_a_q;
    assign bus.ALUSrcB     = alu_src_b_q;
    assign bus.ALUOp       = alu_op_q;
    assign bus.PCSource    = pc_source_q;
    assign bus.MulStart    = mul_start_q;
    assign bus.Illegal     = illegal_q;
    assign bus.State       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: an instruction-level model plans the expected
// state trace, the driver pushes expected output words, and a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

    localparam int MUL_LAT = 3;

    localparam logic [3:0] RST = 4'd0,  FET = 4'd1,  DEC = 4'd2,  ER = 4'd3,  EI = 4'd4;
    localparam logic [3:0] EM  = 4'd5,  MA  = 4'd6,  MR  = 4'd7,  MW = 4'd8,  WA = 4'd9;
    localparam logic [3:0] WM  = 4'd10, BR  = 4'd11, JP  = 4'd12, TR = 4'd13;

    localparam int C_R = 0, C_I = 1, C_MUL = 2, C_LOAD = 3, C_STORE = 4, C_BR = 5, C_JUMP = 6, C_TRAP = 7;

    typedef struct packed {
        logic [3:0] st;
        logic       ready;
        logic       rstn;
        logic       reg_dst;
        logic       mul_first;
        logic [5:0] op;
    } cycle_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cycle_t      plan[$];
    logic [21:0] exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cycle_no = 0;

    logic [5:0] legal_ops [23] = '{6'h00, 6'h1F, 6'h1C, 6'h23, 6'h21, 6'h20, 6'h2B, 6'h29,
                                   6'h28, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                   6'h0F, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02};

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MUL_LATENCY(MUL_LAT)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [5:0] op);
        if (op == 6'h00 || op == 6'h1F)             return C_R;
        if (op == 6'h1C)                            return C_MUL;
        if (op inside {6'h23, 6'h21, 6'h20})        return C_LOAD;
        if (op inside {6'h2B, 6'h29, 6'h28})        return C_STORE;
        if (op >= 6'h08 && op <= 6'h0F)             return C_I;
        if (op == 6'h01 || (op >= 6'h04 && op <= 6'h07)) return C_BR;
        if (op == 6'h02)                            return C_JUMP;
        return C_TRAP;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected datapath controls for one cycle, straight from the state-by-state control table.
    function automatic logic [21:0] expect_bus(input cycle_t c);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ms, ill;
        logic [1:0] sb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ms, ill} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (c.st)
            FET: begin mrd = 1'b1; sb = 2'b01; irw = c.ready; pcw = c.ready; end
            DEC: sb = 2'b11;
            ER:  begin sa = 1'b1; aop = 2'b10; end
            EI:  begin sa = 1'b1; sb = 2'b10; aop = 2'b10; end
            EM:  begin sa = 1'b1; aop = 2'b10; ms = c.mul_first; end
            MA:  begin sa = 1'b1; sb = 2'b10; end
            MR:  begin mrd = 1'b1; iord = 1'b1; end
            MW:  begin mwr = 1'b1; iord = 1'b1; end
            WA:  begin rw = 1'b1; rdst = c.reg_dst; end
            WM:  begin rw = 1'b1; m2r = 1'b1; end
            BR:  begin sa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
            JP:  begin pcw = 1'b1; psrc = 2'b10; end
            TR:  ill = 1'b1;
            default: ;
        endcase
        return {c.st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, psrc, ms, ill};
    endfunction

    task automatic add(input logic [3:0] st, input logic ready, input logic rstn,
                       input logic reg_dst, input logic mul_first, input logic [5:0] op);
        cycle_t c;
        c.st = st; c.ready = ready; c.rstn = rstn;
        c.reg_dst = reg_dst; c.mul_first = mul_first; c.op = op;
        plan.push_back(c);
    endtask

    task automatic add_reset(input int n, input logic [5:0] op);
        for (int i = 0; i < n; i++) add(RST, rb(), 1'b0, 1'b0, 1'b0, op);
        add(RST, rb(), 1'b1, 1'b0, 1'b0, op);
    endtask

    task automatic add_fetch(input logic [5:0] op, input int fetch_stall);
        for (int i = 0; i < fetch_stall; i++) add(FET, 1'b0, 1'b1, 1'b0, 1'b0, op);
        add(FET, 1'b1, 1'b1, 1'b0, 1'b0, op);
        add(DEC, rb(), 1'b1, 1'b0, 1'b0, op);
    endtask

    // One whole instruction as the sequence of states it must visit, cycle by cycle.
    task automatic add_instr(input logic [5:0] op, input int fetch_stall, input int mem_stall);
        add_fetch(op, fetch_stall);
        case (classify(op))
            C_R: begin
                add(ER, rb(), 1'b1, 1'b0, 1'b0, op);
                add(WA, rb(), 1'b1, 1'b1, 1'b0, op);
            end
            C_I: begin
                add(EI, rb(), 1'b1, 1'b0, 1'b0, op);
                add(WA, rb(), 1'b1, 1'b0, 1'b0, op);
            end
            C_MUL: begin
                for (int i = 0; i < MUL_LAT; i++) add(EM, rb(), 1'b1, 1'b0, 1'(i == 0), op);
                add(WA, rb(), 1'b1, 1'b1, 1'b0, op);
            end
            C_LOAD: begin
                add(MA, rb(), 1'b1, 1'b0, 1'b0, op);
                for (int i = 0; i < mem_stall; i++) add(MR, 1'b0, 1'b1, 1'b0, 1'b0, op);
                add(MR, 1'b1, 1'b1, 1'b0, 1'b0, op);
                add(WM, rb(), 1'b1, 1'b0, 1'b0, op);
            end
            C_STORE: begin
                add(MA, rb(), 1'b1, 1'b0, 1'b0, op);
                for (int i = 0; i < mem_stall; i++) add(MW, 1'b0, 1'b1, 1'b0, 1'b0, op);
                add(MW, 1'b1, 1'b1, 1'b0, 1'b0, op);
            end
            C_BR:   add(BR, rb(), 1'b1, 1'b0, 1'b0, op);
            C_JUMP: add(JP, rb(), 1'b1, 1'b0, 1'b0, op);
            default: begin
                for (int i = 0; i < 3; i++) add(TR, rb(), 1'b1, 1'b0, 1'b0, op);
                add_reset(2, op);
            end
        endcase
    endtask

    task automatic build_plan();
        logic [5:0] op;
        for (int i = 0; i < 3; i++) add(RST, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);
        add(RST, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00);
        add_instr(6'h00, 0, 0);
        add_instr(6'h23, 0, 2);
        add_instr(6'h1C, 0, 0);
        add_instr(6'h04, 0, 0);
        add_instr(6'h2B, 1, 1);
        add_instr(6'h0F, 2, 0);
        add_instr(6'h02, 0, 0);
        add_instr(6'h3F, 0, 0);
        add_fetch(6'h1C, 0);
        add(EM, rb(), 1'b1, 1'b0, 1'b1, 6'h1C);
        add_reset(2, 6'h1C);
        add_instr(6'h1C, 1, 0);
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 22)];
            else                          op = 6'($urandom_range(0, 63));
            add_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic applyStimulus();
        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            rst_n        = plan[i].rstn;
            bus.Opcode   = plan[i].op;
            bus.MemReady = plan[i].ready;
            exp_q.push_back(expect_bus(plan[i]));
        end
    endtask

    task automatic checkOutput();
        logic [21:0] exp_w, act_w;
        exp_w = exp_q.pop_front();
        act_w = {bus.State, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                 bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                 bus.ALUOp, bus.PCSource, bus.MulStart, bus.Illegal};
        compared++;
        if (act_w !== exp_w) begin
            mismatched++;
            $display("[TB] FAIL cycle%0d outputs: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                     cycle_no, act_w[21:18], act_w[17:0], exp_w[21:18], exp_w[17:0]);
        end
        cycle_no++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput();
    end

    initial begin
        bus.Opcode   = 6'h00;
        bus.MemReady = 1'b1;
        build_plan();
        applyStimulus();
        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0 || cycle_no != plan.size()) begin
            mismatched++;
            $display("[TB] FAIL drain: checked %0d cycles with %0d pending, expected %0d checked and 0 pending",
                     cycle_no, exp_q.size(), plan.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
